// File: rtl/tap_scan_sequencer.sv
// Host-side TAP sequencer: turns reset / IR scan / DR scan / dwell commands into
// TMS/TDI pad streams, captures TDO and checks the TAP lands in Run-Test/Idle.
module tap_scan_sequencer #(
  parameter int         MAX_BITS = 16,
  parameter int         LEN_W    = 5,
  parameter logic [2:0] RTI_CODE = 3'd1
) (
  input  logic                GCLK_Pad,
  input  logic                Rst_Pad,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic [MAX_BITS-1:0] cmd_data,
  output logic                TMS_Pad,
  output logic                TDI_Pad,
  input  logic                TDO_Pad,
  input  logic [2:0]          St_obs,
  output logic                rsp_valid,
  output logic [MAX_BITS-1:0] rsp_data,
  output logic                rsp_err,
  output logic                busy
);

  typedef enum logic [2:0] {S_AUTO, S_IDLE, S_PRE, S_SHIFT, S_POST, S_CHECK} state_t;

  localparam logic [1:0]       OP_RST   = 2'b00;
  localparam logic [1:0]       OP_IR    = 2'b01;
  localparam logic [1:0]       OP_DR    = 2'b10;
  localparam logic [1:0]       OP_DWELL = 2'b11;
  localparam logic [LEN_W-1:0] ONE      = LEN_W'(1);

  state_t              r_state;
  state_t              w_next;
  logic [LEN_W-1:0]    r_cnt;
  logic [1:0]          r_op;
  logic [LEN_W-1:0]    r_len;
  logic [MAX_BITS-1:0] r_sh;
  logic [MAX_BITS-1:0] r_cap;
  logic                r_rsp_valid;
  logic                r_rsp_err;
  logic [MAX_BITS-1:0] r_rsp_data;
  logic                w_tms;
  logic                w_last;
  logic                w_accept;

  function automatic logic [LEN_W-1:0] scan_len(input logic [LEN_W-1:0] len);
    if (len == '0)
      return ONE;
    else if (len > LEN_W'(MAX_BITS))
      return LEN_W'(MAX_BITS);
    else
      return len;
  endfunction

  assign w_accept = (r_state == S_IDLE) && cmd_valid;

  always_comb begin
    w_next = r_state;
    w_tms  = 1'b0;
    w_last = 1'b0;
    case (r_state)
      S_AUTO: begin
        w_tms = (r_cnt < LEN_W'(5));
        if (r_cnt == LEN_W'(5)) w_next = S_IDLE;
      end
      S_IDLE: begin
        if (cmd_valid)
          w_next = (cmd_op == OP_DWELL && cmd_len == '0) ? S_CHECK : S_PRE;
      end
      S_PRE: begin
        // Per-op lead-in walks the TAP from Run-Test/Idle to its Shift state
        case (r_op)
          OP_RST: begin
            w_tms  = (r_cnt < LEN_W'(5));
            w_last = (r_cnt == LEN_W'(5));
          end
          OP_IR: begin
            w_tms  = (r_cnt < LEN_W'(2));
            w_last = (r_cnt == LEN_W'(3));
          end
          OP_DR: begin
            w_tms  = (r_cnt == '0);
            w_last = (r_cnt == LEN_W'(2));
          end
          default: begin
            w_tms  = 1'b0;
            w_last = (r_cnt == r_len - ONE);
          end
        endcase
        if (w_last)
          w_next = (r_op == OP_RST || r_op == OP_DWELL) ? S_CHECK : S_SHIFT;
      end
      S_SHIFT: begin
        w_tms = (r_cnt == r_len - ONE);
        if (w_tms) w_next = S_POST;
      end
      S_POST: begin
        w_tms = (r_cnt == '0);
        if (r_cnt == ONE) w_next = S_CHECK;
      end
      S_CHECK: w_next = S_IDLE;
      default: w_next = S_AUTO;
    endcase
  end

  always_ff @(posedge GCLK_Pad) begin
    if (Rst_Pad) begin
      r_state <= S_AUTO;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? '0 : r_cnt + ONE;
    end
  end

  always_ff @(posedge GCLK_Pad) begin
    if (w_accept) begin
      r_op  <= cmd_op;
      r_len <= (cmd_op == OP_DWELL) ? cmd_len : scan_len(cmd_len);
      r_sh  <= cmd_data;
      r_cap <= '0;
    end else if (r_state == S_SHIFT) begin
      r_sh  <= r_sh >> 1;
      r_cap <= r_cap | ({{(MAX_BITS-1){1'b0}}, TDO_Pad} << r_cnt);
    end
  end

  always_ff @(posedge GCLK_Pad) begin
    if (Rst_Pad) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= (r_state == S_CHECK);
      if (r_state == S_CHECK) begin
        r_rsp_err  <= (St_obs != RTI_CODE);
        r_rsp_data <= r_cap;
      end
    end
  end

  assign TMS_Pad   = w_tms;
  assign TDI_Pad   = (r_state == S_SHIFT) && r_sh[0];
  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_tap_scan_sequencer.sv
// Bench for tap_scan_sequencer: directed vector table, hand-written reset corner
// cases and random commands checked against a per-cycle pad-stream model.
module tb_tap_scan_sequencer;

  localparam int         MAX_BITS = 16;
  localparam int         LEN_W    = 5;
  localparam logic [2:0] RTI      = 3'd1;

  logic                GCLK_Pad = 1'b0;
  logic                Rst_Pad;
  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_op;
  logic [LEN_W-1:0]    cmd_len;
  logic [MAX_BITS-1:0] cmd_data;
  logic                TMS_Pad;
  logic                TDI_Pad;
  logic                TDO_Pad;
  logic [2:0]          St_obs;
  logic                rsp_valid;
  logic [MAX_BITS-1:0] rsp_data;
  logic                rsp_err;
  logic                busy;

  int tests  = 0;
  int failed = 0;

  tap_scan_sequencer #(.MAX_BITS(MAX_BITS), .LEN_W(LEN_W), .RTI_CODE(RTI)) dut (
    .GCLK_Pad(GCLK_Pad), .Rst_Pad(Rst_Pad), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data), .TMS_Pad(TMS_Pad),
    .TDI_Pad(TDI_Pad), .TDO_Pad(TDO_Pad), .St_obs(St_obs), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 GCLK_Pad = ~GCLK_Pad;

  typedef struct {
    logic [1:0]       op;
    logic [LEN_W-1:0] len;
    logic [15:0]      data;
    logic [15:0]      tdo;
    logic [2:0]       st;
    int               lat;
    logic [15:0]      rd;
    logic             re;
  } vec_t;

  vec_t tbl[10];

  task automatic step();
    @(posedge GCLK_Pad);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Starts in the first cycle after reset release; ends in the first IDLE cycle.
  task automatic auto_check(input string tag);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("%s auto c%0d {tms,ready,busy,rspv}", tag, i + 1),
          32'({TMS_Pad, cmd_ready, busy, rsp_valid}), 32'({(i < 5), 1'b0, 1'b1, 1'b0}));
      step();
    end
    chk($sformatf("%s idle {tms,tdi,ready,busy,rspv}", tag),
        32'({TMS_Pad, TDI_Pad, cmd_ready, busy, rsp_valid}), 32'(5'b00100));
  endtask

  // Issues one command from an IDLE cycle and walks it to its response cycle.
  task automatic issue(input logic [1:0] op, input logic [LEN_W-1:0] len,
                       input logic [15:0] data, input logic [15:0] tdo,
                       input logic [2:0] st, input bit hold,
                       output int lat, output logic [15:0] rd, output logic re);
    bit          qt[$];
    bit          qd[$];
    int          qi[$];
    int          n;
    int          w;
    logic [15:0] exp_rd;
    exp_rd = '0;
    n = 0;
    case (op)
      2'b00: begin
        for (int k = 0; k < 6; k++) begin qt.push_back(k < 5); qd.push_back(0); qi.push_back(-1); end
      end
      2'b11: begin
        for (int k = 0; k < int'(len); k++) begin qt.push_back(0); qd.push_back(0); qi.push_back(-1); end
      end
      default: begin
        if (op == 2'b01) begin
          qt.push_back(1); qt.push_back(1); qt.push_back(0); qt.push_back(0);
          repeat (4) begin qd.push_back(0); qi.push_back(-1); end
        end else begin
          qt.push_back(1); qt.push_back(0); qt.push_back(0);
          repeat (3) begin qd.push_back(0); qi.push_back(-1); end
        end
        n = (len == 0) ? 1 : ((int'(len) > MAX_BITS) ? MAX_BITS : int'(len));
        for (int k = 0; k < n; k++) begin
          qt.push_back(k == n - 1); qd.push_back(data[k]); qi.push_back(k);
          exp_rd[k] = tdo[k];
        end
        qt.push_back(1); qt.push_back(0);
        repeat (2) begin qd.push_back(0); qi.push_back(-1); end
      end
    endcase
    qt.push_back(0); qd.push_back(0); qi.push_back(-1);
    lat = qt.size() + 1;

    w = 0;
    while (!cmd_ready && w < 100) begin step(); w++; end
    if (!cmd_ready) begin
      chk("ready_timeout", 32'(cmd_ready), 32'(1));
      rd = rsp_data; re = rsp_err;
      return;
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_len = len; cmd_data = data;
    step();
    if (hold) begin
      cmd_op = op + 2'd1; cmd_len = 5'd7; cmd_data = ~data;
    end else begin
      cmd_valid = 1'b0;
    end
    for (int j = 0; j < qt.size(); j++) begin
      chk($sformatf("walk op%0d c%0d {tms,tdi,busy,rspv,ready}", op, j + 1),
          32'({TMS_Pad, TDI_Pad, busy, rsp_valid, cmd_ready}),
          32'({qt[j], qd[j], 1'b1, 1'b0, 1'b0}));
      TDO_Pad = (qi[j] >= 0) ? tdo[qi[j]] : 1'($urandom);
      St_obs  = (j == qt.size() - 1) ? st : ~st;
      step();
    end
    cmd_valid = 1'b0;
    St_obs = RTI;
    chk($sformatf("rsp op%0d {rspv,ready,busy}", op),
        32'({rsp_valid, cmd_ready, busy}), 32'(3'b110));
    chk($sformatf("rsp op%0d data", op), 32'(rsp_data), 32'(exp_rd));
    chk($sformatf("rsp op%0d err", op), 32'(rsp_err), 32'(st != RTI));
    rd = rsp_data;
    re = rsp_err;
  endtask

  initial begin
    int          lat;
    logic [15:0] rd;
    logic        re;
    logic [1:0]  op;
    logic [4:0]  len;

    tbl[0] = '{2'b10, 5'd4,  16'h000B, 16'h0006, 3'd1, 11, 16'h0006, 1'b0};
    tbl[1] = '{2'b01, 5'd3,  16'h0005, 16'h0003, 3'd1, 11, 16'h0003, 1'b0};
    tbl[2] = '{2'b10, 5'd2,  16'h0002, 16'h0003, 3'd5,  9, 16'h0003, 1'b1};
    tbl[3] = '{2'b10, 5'd2,  16'h0001, 16'h0000, 3'd1,  9, 16'h0000, 1'b0};
    tbl[4] = '{2'b10, 5'd5,  16'h0015, 16'h001F, 3'd1, 12, 16'h001F, 1'b0};
    tbl[5] = '{2'b11, 5'd0,  16'h0000, 16'h0000, 3'd1,  2, 16'h0000, 1'b0};
    tbl[6] = '{2'b10, 5'd20, 16'hA5C3, 16'hFFFF, 3'd1, 23, 16'hFFFF, 1'b0};
    tbl[7] = '{2'b00, 5'd0,  16'h0000, 16'hFFFF, 3'd1,  8, 16'h0000, 1'b0};
    tbl[8] = '{2'b01, 5'd0,  16'h0001, 16'h0001, 3'd1,  9, 16'h0001, 1'b0};
    tbl[9] = '{2'b11, 5'd5,  16'h0000, 16'h0000, 3'd2,  7, 16'h0000, 1'b1};

    Rst_Pad = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_len = '0; cmd_data = '0;
    TDO_Pad = 1'b0; St_obs = RTI;

    step();
    chk("reset {tms,tdi,ready,rspv,err,busy}",
        32'({TMS_Pad, TDI_Pad, cmd_ready, rsp_valid, rsp_err, busy}), 32'(6'b100001));
    chk("reset rsp_data", 32'(rsp_data), 32'(0));
    step(); step();
    Rst_Pad = 1'b0;
    auto_check("power-up");

    for (int i = 0; i < 10; i++) begin
      issue(tbl[i].op, tbl[i].len, tbl[i].data, tbl[i].tdo, tbl[i].st, 1'b0, lat, rd, re);
      chk($sformatf("tbl%0d latency", i), 32'(lat), 32'(tbl[i].lat));
      chk($sformatf("tbl%0d rsp_data", i), 32'(rd), 32'(tbl[i].rd));
      chk($sformatf("tbl%0d rsp_err", i), 32'(re), 32'(tbl[i].re));
    end

    step();
    chk("pulse ends {rspv,ready}", 32'({rsp_valid, cmd_ready}), 32'(2'b01));
    chk("rsp_err holds", 32'(rsp_err), 32'(1));

    issue(2'b10, 5'd6, 16'h0033, 16'h002A, 3'd1, 1'b1, lat, rd, re);
    step();

    // Abort a DR len=8 scan during its second shift bit
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_len = 5'd8; cmd_data = 16'h00FF;
    step();
    cmd_valid = 1'b0;
    repeat (4) step();
    chk("abort in shift {tms,tdi,busy}", 32'({TMS_Pad, TDI_Pad, busy}), 32'(3'b011));
    Rst_Pad = 1'b1;
    step();
    Rst_Pad = 1'b0;
    chk("abort reset {tms,tdi,ready,rspv,err,busy}",
        32'({TMS_Pad, TDI_Pad, cmd_ready, rsp_valid, rsp_err, busy}), 32'(6'b100001));
    chk("abort rsp_data", 32'(rsp_data), 32'(0));
    auto_check("abort");
    for (int i = 0; i < 12; i++) begin
      step();
      chk("abort no late rsp {rspv,ready}", 32'({rsp_valid, cmd_ready}), 32'(2'b01));
    end

    for (int r = 0; r < 40; r++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        step();
        chk("rand gap idle {tms,tdi,ready,busy,rspv}",
            32'({TMS_Pad, TDI_Pad, cmd_ready, busy, rsp_valid}), 32'(5'b00100));
      end
      op  = 2'($urandom_range(0, 3));
      len = (op == 2'b11) ? 5'($urandom_range(0, 8)) : 5'($urandom_range(0, 20));
      issue(op, len, 16'($urandom), 16'($urandom),
            ($urandom_range(0, 1) != 0) ? RTI : 3'($urandom_range(0, 7)),
            ($urandom_range(0, 3) == 0), lat, rd, re);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
